// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers; 34-cycle issue interval,
// busy high from launch through commit. Optional MULDIV_FAST_MUL_EN: single-cycle multiplier path.
module muldiv_unit (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iStart,
  input  logic [1:0]  iOp,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  input  logic        iHiWe,
  input  logic        iLoWe,
  input  logic [31:0] iWdata,
  output logic        oBusy,
  output logic        oDone,
  output logic [31:0] oHi,
  output logic [31:0] oLo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q;
  logic        sign_a_q, sign_b_q, dbz_q;
  logic [31:0] a_q, b_q, a_orig_q;
  logic [5:0]  cnt_q;
  logic [63:0] acc_q;

  // Magnitudes of the incoming operands; MULT/DIV (iOp[0]==0) are the signed ops.
  logic        sa_in, sb_in;
  logic [31:0] abs_a_in, abs_b_in;
  logic [63:0] acc_init;
  logic        start_to_fix;

  assign sa_in    = ~iOp[0] & iA[31];
  assign sb_in    = ~iOp[0] & iB[31];
  assign abs_a_in = sa_in ? (32'd0 - iA) : iA;
  assign abs_b_in = sb_in ? (32'd0 - iB) : iB;

`ifdef MULDIV_FAST_MUL_EN
  assign start_to_fix = ~iOp[1];
  assign acc_init     = iOp[1] ? 64'd0 : ({32'd0, abs_a_in} * {32'd0, abs_b_in});
`else
  assign start_to_fix = 1'b0;
  assign acc_init     = 64'd0;
`endif

  // Multiply step: add multiplicand into the high half, then shift the whole accumulator right.
  logic [32:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[63:32]} + (b_q[0] ? {1'b0, a_q} : 33'd0);

  // Divide step: acc = {remainder, quotient}; dividend bits enter from a_q MSB first.
  logic [32:0] rem_sh;
  logic [33:0] div_diff;
  logic        q_bit;
  logic [31:0] rem_new;
  assign rem_sh   = {acc_q[63:32], a_q[31]};
  assign div_diff = {1'b0, rem_sh} - {2'b00, b_q};
  assign q_bit    = ~div_diff[33];
  assign rem_new  = q_bit ? div_diff[31:0] : rem_sh[31:0];

  logic [31:0] fix_hi, fix_lo;
  logic [63:0] prod;
  logic        neg_res;

  always_comb begin
    neg_res = ~op_q[0] & (sign_a_q ^ sign_b_q);
    prod    = neg_res ? (64'd0 - acc_q) : acc_q;
    fix_hi  = prod[63:32];
    fix_lo  = prod[31:0];
    if (op_q[1]) begin
      if (dbz_q) begin
        fix_hi = a_orig_q;
        fix_lo = 32'hFFFF_FFFF;
      end else begin
        fix_lo = neg_res ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        fix_hi = (~op_q[0] & sign_a_q) ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (iStart) state_d = start_to_fix ? FIX : RUN;
      RUN:     if (cnt_q == 6'd31) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      op_q     <= 2'd0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dbz_q    <= 1'b0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      a_orig_q <= 32'd0;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
      oHi      <= 32'd0;
      oLo      <= 32'd0;
    end else begin
      oDone <= 1'b0;
      case (state_q)
        IDLE: begin
          if (iHiWe) oHi <= iWdata;
          if (iLoWe) oLo <= iWdata;
          if (iStart) begin
            op_q     <= iOp;
            sign_a_q <= sa_in;
            sign_b_q <= sb_in;
            a_q      <= abs_a_in;
            b_q      <= abs_b_in;
            a_orig_q <= iA;
            dbz_q    <= iOp[1] & (iB == 32'd0);
            cnt_q    <= 6'd0;
            acc_q    <= acc_init;
            oBusy    <= 1'b1;
          end
        end
        RUN: begin
          cnt_q <= cnt_q + 6'd1;
          if (op_q[1]) begin
            acc_q <= {rem_new, acc_q[30:0], q_bit};
            a_q   <= {a_q[30:0], 1'b0};
          end else begin
            acc_q <= {mul_sum, acc_q[31:1]};
            b_q   <= {1'b0, b_q[31:1]};
          end
        end
        FIX: begin
          oBusy <= 1'b0;
          oDone <= 1'b1;
          oHi   <= fix_hi;
          oLo   <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule
